// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing, mu fixed-point format and sweep state encoding
// for the VGA scan generator and its mu sweep.
package vga_pkg;

  localparam int unsigned VGA_H_VIS   = 640;
  localparam int unsigned VGA_H_FP    = 16;
  localparam int unsigned VGA_H_SYNC  = 96;
  localparam int unsigned VGA_H_BP    = 48;
  localparam int unsigned VGA_V_VIS   = 480;
  localparam int unsigned VGA_V_FP    = 10;
  localparam int unsigned VGA_V_SYNC  = 2;
  localparam int unsigned VGA_V_BP    = 33;
  localparam int unsigned VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned ROW_W = 10;
  localparam int unsigned COL_W = 10;

  // mu is unsigned 2.16 fixed point: 2 integer bits, 16 fraction bits
  localparam int unsigned MU_W = 18;
  typedef logic [MU_W-1:0] mu_t;

  localparam mu_t         MU_MIN_DEF          = 18'h2_8000;
  localparam mu_t         MU_MAX_DEF          = 18'h3_FFFF;
  localparam mu_t         MU_STEP_DEF         = 18'h0_0040;
  localparam int unsigned FRAMES_PER_STEP_DEF = 4;

  typedef enum logic [1:0] {
    SWEEP_UP   = 2'd0,
    SWEEP_DOWN = 2'd1,
    SWEEP_HOLD = 2'd2
  } sweep_state_e;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

endpackage

// File: rtl/mu_sweep.sv
// Per-frame mu sweep: bounces mu between MU_MIN and MU_MAX, stepping once every
// FRAMES_PER_STEP frames; only acts in the frame_start cycle so mu is frame-stable.
module mu_sweep
  import vga_pkg::*;
#(
  parameter mu_t         MU_MIN          = MU_MIN_DEF,
  parameter mu_t         MU_MAX          = MU_MAX_DEF,
  parameter mu_t         MU_STEP         = MU_STEP_DEF,
  parameter int unsigned FRAMES_PER_STEP = FRAMES_PER_STEP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start_i,
  input  logic sweep_en_i,
  output mu_t  mu_o
);

  localparam int unsigned      CNT_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [MU_W:0]    MAX_X    = {1'b0, MU_MAX};
  localparam logic [MU_W:0]    DN_LIM_X = {1'b0, MU_MIN} + {1'b0, MU_STEP};

  sweep_state_e     state_q, state_d;
  sweep_state_e     dir_q, dir_d;
  sweep_state_e     run_dir;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mu_t              mu_q, mu_d;
  logic [MU_W:0]    mu_up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SWEEP_UP;
      dir_q   <= SWEEP_UP;
      cnt_q   <= '0;
      mu_q    <= MU_MIN;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      mu_q    <= mu_d;
    end
  end

  // Comparisons in MU_W+1 bits so the step can never wrap mu.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    mu_d    = mu_q;
    run_dir = (state_q == SWEEP_HOLD) ? dir_q : state_q;
    mu_up   = {1'b0, mu_q} + {1'b0, MU_STEP};
    if (frame_start_i) begin
      if (!sweep_en_i) begin
        state_d = SWEEP_HOLD;
      end else begin
        state_d = run_dir;
        dir_d   = run_dir;
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (run_dir == SWEEP_DOWN) begin
            if ({1'b0, mu_q} < DN_LIM_X) begin
              mu_d    = MU_MIN;
              state_d = SWEEP_UP;
              dir_d   = SWEEP_UP;
            end else begin
              mu_d = mu_q - MU_STEP;
            end
          end else begin
            if (mu_up > MAX_X) begin
              mu_d    = MU_MAX;
              state_d = SWEEP_DOWN;
              dir_d   = SWEEP_DOWN;
            end else begin
              mu_d = mu_up[MU_W-1:0];
            end
          end
        end
      end
    end
  end

  assign mu_o = mu_q;

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: row/col counters at CLK/2, registered colour and sync
// outputs one pixel behind row/col, and the per-frame mu sweep for the colouriser.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS           = VGA_H_VIS,
  parameter int unsigned H_FP            = VGA_H_FP,
  parameter int unsigned H_SYNC          = VGA_H_SYNC,
  parameter int unsigned H_BP            = VGA_H_BP,
  parameter int unsigned V_VIS           = VGA_V_VIS,
  parameter int unsigned V_FP            = VGA_V_FP,
  parameter int unsigned V_SYNC          = VGA_V_SYNC,
  parameter int unsigned V_BP            = VGA_V_BP,
  parameter mu_t         MU_MIN          = MU_MIN_DEF,
  parameter mu_t         MU_MAX          = MU_MAX_DEF,
  parameter mu_t         MU_STEP         = MU_STEP_DEF,
  parameter int unsigned FRAMES_PER_STEP = FRAMES_PER_STEP_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sweep_en,
  input  logic             red_in,
  input  logic             green_in,
  input  logic             blue_in,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output mu_t              mu,
  output logic             frame_start,
  output logic             r,
  output logic             g,
  output logic             b,
  output logic             hsync,
  output logic             vsync
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_TOTAL - 1);
  localparam logic [COL_W-1:0] COL_VIS  = COL_W'(H_VIS);
  localparam logic [COL_W-1:0] HS_BEG   = COL_W'(H_VIS + H_FP);
  localparam logic [COL_W-1:0] HS_END   = COL_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_TOTAL - 1);
  localparam logic [ROW_W-1:0] ROW_VIS  = ROW_W'(V_VIS);
  localparam logic [ROW_W-1:0] VS_BEG   = ROW_W'(V_VIS + V_FP);
  localparam logic [ROW_W-1:0] VS_END   = ROW_W'(V_VIS + V_FP + V_SYNC);

  logic             pix_en_q;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             fs_q, fs_d;
  rgb_t             rgb_q, rgb_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             col_wrap;
  logic             row_wrap;
  logic             visible;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pix_en_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      fs_q     <= 1'b0;
      rgb_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      pix_en_q <= ~pix_en_q;
      col_q    <= col_d;
      row_q    <= row_d;
      fs_q     <= fs_d;
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  // Colour and syncs decode the pre-tick row/col, so both land on the same edge.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    fs_d     = 1'b0;
    rgb_d    = rgb_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    col_wrap = (col_q == COL_LAST);
    row_wrap = (row_q == ROW_LAST);
    visible  = (col_q < COL_VIS) && (row_q < ROW_VIS);
    if (pix_en_q) begin
      col_d = col_wrap ? '0 : col_q + COL_W'(1);
      if (col_wrap) begin
        row_d = row_wrap ? '0 : row_q + ROW_W'(1);
      end
      fs_d  = col_wrap && row_wrap;
      rgb_d = {red_in & visible, green_in & visible, blue_in & visible};
      hs_d  = !((col_q >= HS_BEG) && (col_q < HS_END));
      vs_d  = !((row_q >= VS_BEG) && (row_q < VS_END));
    end
  end

  mu_sweep #(
    .MU_MIN         (MU_MIN),
    .MU_MAX         (MU_MAX),
    .MU_STEP        (MU_STEP),
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_mu_sweep (
    .clk          (CLK),
    .rst_n        (RST),
    .frame_start_i(fs_q),
    .sweep_en_i   (sweep_en),
    .mu_o         (mu)
  );

  assign row         = row_q;
  assign col         = col_q;
  assign frame_start = fs_q;
  assign r           = rgb_q.r;
  assign g           = rgb_q.g;
  assign b           = rgb_q.b;
  assign hsync       = hs_q;
  assign vsync       = vs_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen on a shrunken raster (33x17) with two mu sweep setups,
// checked cycle by cycle against an arithmetic model of the scan and mu rules.
module tb_vga_scan_gen;

  localparam int TH_VIS = 20, TH_FP = 4, TH_SYNC = 6, TH_BP = 3;
  localparam int TV_VIS = 10, TV_FP = 2, TV_SYNC = 2, TV_BP = 3;
  localparam int HT = TH_VIS + TH_FP + TH_SYNC + TH_BP;
  localparam int VT = TV_VIS + TV_FP + TV_SYNC + TV_BP;
  localparam int F  = HT * VT;

  localparam int M1_STEP = 'h10000, M1_FPS = 1;
  localparam int M2_STEP = 'h04000, M2_FPS = 3;
  localparam int MU_LO   = 'h28000, MU_HI = 'h3FFFF;

  typedef struct {
    bit          en;
    logic [17:0] mu;
  } vec_t;

  logic        CLK, RST, sweep_en, red_in, green_in, blue_in;
  logic [9:0]  row, col, row2, col2;
  logic [17:0] mu, mu2;
  logic        frame_start, r, g, b, hsync, vsync;
  logic        frame_start2, r2, g2, b2, hsync2, vsync2;

  int          n_cmp, n_bad;
  int          e;
  logic [2:0]  last_rgb, rgb_drv;
  int          m1_mu, m1_cnt, m2_mu, m2_cnt;
  bit          m1_up, m2_up;
  int          fs_seen, hs_low, vs_low;
  vec_t        tbl[9];

  vga_scan_gen #(
    .H_VIS(TH_VIS), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
    .V_VIS(TV_VIS), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
    .MU_STEP(18'h1_0000), .FRAMES_PER_STEP(1)
  ) dut (
    .CLK(CLK), .RST(RST), .sweep_en(sweep_en),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .row(row), .col(col), .mu(mu), .frame_start(frame_start),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync)
  );

  vga_scan_gen #(
    .H_VIS(TH_VIS), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
    .V_VIS(TV_VIS), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
    .MU_STEP(18'h0_4000), .FRAMES_PER_STEP(3)
  ) dut2 (
    .CLK(CLK), .RST(RST), .sweep_en(sweep_en),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .row(row2), .col(col2), .mu(mu2), .frame_start(frame_start2),
    .r(r2), .g(g2), .b(b2), .hsync(hsync2), .vsync(vsync2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, e, $time);
    end
  endtask

  task automatic model_step(input int mu_i, input bit up_i, input int cnt_i, input int fps,
                            input int stp, input bit en, output int mu_o, output bit up_o,
                            output int cnt_o);
    mu_o = mu_i; up_o = up_i; cnt_o = cnt_i;
    if (en) begin
      if (cnt_i == fps - 1) begin
        cnt_o = 0;
        if (up_i) begin
          if (mu_i + stp > MU_HI) begin mu_o = MU_HI; up_o = 1'b0; end
          else mu_o = mu_i + stp;
        end else begin
          if (mu_i - stp < MU_LO) begin mu_o = MU_LO; up_o = 1'b1; end
          else mu_o = mu_i - stp;
        end
      end else begin
        cnt_o = cnt_i + 1;
      end
    end
  endtask

  task automatic model_reset();
    e = 0;
    m1_mu = MU_LO; m1_up = 1'b1; m1_cnt = 0;
    m2_mu = MU_LO; m2_up = 1'b1; m2_cnt = 0;
    fs_seen = 0; hs_low = 0; vs_low = 0;
  endtask

  // Expected outputs after e CLK edges since reset release: tick count is e/2.
  task automatic check_outputs();
    int t, pos, lp, lrow, lcol, erow, ecol;
    bit vis, efs, ehs, evs;
    logic [2:0] ergb;
    t    = e / 2;
    pos  = t % F;
    erow = pos / HT;
    ecol = pos % HT;
    efs  = (e >= 2) && (e % 2 == 0) && (pos == 0);
    ergb = 3'b000; ehs = 1'b1; evs = 1'b1;
    if (t > 0) begin
      lp   = (t - 1) % F;
      lrow = lp / HT;
      lcol = lp % HT;
      vis  = (lcol < TH_VIS) && (lrow < TV_VIS);
      ergb = vis ? last_rgb : 3'b000;
      ehs  = !((lcol >= TH_VIS + TH_FP) && (lcol < TH_VIS + TH_FP + TH_SYNC));
      evs  = !((lrow >= TV_VIS + TV_FP) && (lrow < TV_VIS + TV_FP + TV_SYNC));
    end
    chk("row", int'(row), erow);
    chk("col", int'(col), ecol);
    chk("frame_start", int'(frame_start), int'(efs));
    chk("rgb", int'({r, g, b}), int'(ergb));
    chk("hsync", int'(hsync), int'(ehs));
    chk("vsync", int'(vsync), int'(evs));
    chk("mu", int'(mu), m1_mu);
    chk("scan2", int'({row2, col2, frame_start2, r2, g2, b2, hsync2, vsync2}),
        int'({10'(erow), 10'(ecol), efs, ergb, ehs, evs}));
    chk("mu2", int'(mu2), m2_mu);
  endtask

  task automatic step_cycle();
    bit fs_now;
    check_outputs();
    if (e >= 2 && e < 2 + 2 * F) begin
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
    end
    if (frame_start) fs_seen++;
    rgb_drv = 3'($urandom_range(0, 7));
    {red_in, green_in, blue_in} = rgb_drv;
    fs_now = (e >= 2) && (e % 2 == 0) && ((e / 2) % F == 0);
    @(posedge CLK);
    e++;
    if (e % 2 == 0) last_rgb = rgb_drv;
    if (fs_now) begin
      model_step(m1_mu, m1_up, m1_cnt, M1_FPS, M1_STEP, sweep_en, m1_mu, m1_up, m1_cnt);
      model_step(m2_mu, m2_up, m2_cnt, M2_FPS, M2_STEP, sweep_en, m2_mu, m2_up, m2_cnt);
    end
    @(negedge CLK);
  endtask

  initial begin
    // {sweep_en from mid-frame k, mu during frame k} for step 1.0, one frame per step
    tbl[0] = '{1'b1, 18'h2_8000};
    tbl[1] = '{1'b1, 18'h3_8000};
    tbl[2] = '{1'b1, 18'h3_FFFF};
    tbl[3] = '{1'b0, 18'h2_FFFF};
    tbl[4] = '{1'b0, 18'h2_FFFF};
    tbl[5] = '{1'b0, 18'h2_FFFF};
    tbl[6] = '{1'b1, 18'h2_FFFF};
    tbl[7] = '{1'b1, 18'h2_8000};
    tbl[8] = '{1'b1, 18'h3_8000};

    n_cmp = 0; n_bad = 0;
    last_rgb = 3'b000; rgb_drv = 3'b000;
    RST = 1'b0; sweep_en = 1'b1;
    red_in = 1'b0; green_in = 1'b0; blue_in = 1'b0;
    model_reset();

    repeat (3) @(negedge CLK);
    check_outputs();
    RST = 1'b1;

    for (int k = 0; k < 9; k++) begin
      while (e < 2 * (k * F + F / 2)) step_cycle();
      chk("mu_table", int'(mu), int'(tbl[k].mu));
      sweep_en = tbl[k].en;
    end

    // Async reset mid-frame at row 12, col 27 (hsync and vsync both low here).
    while (e < 2 * (9 * F + 12 * HT + 27)) step_cycle();
    check_outputs();
    #2 RST = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("mu_async_rst", int'(mu), MU_LO);
    @(negedge CLK);
    check_outputs();
    RST = 1'b1;

    while (e < 4 * F + 20) step_cycle();
    chk("hsync_low_per_frame", hs_low, 2 * TH_SYNC * VT);
    chk("vsync_low_per_frame", vs_low, 2 * TV_SYNC * HT);
    chk("frame_start_count", fs_seen, ((e - 1) / 2) / F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
